// File: rtl/wb_pkg.sv
// Shared types and default widths for the write-back arbiter.
package wb_pkg;

    // Write-back source; the encoding equals the memtoreg select value.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    localparam int WB_W  = 32;
    localparam int WB_AW = 5;

endpackage

// File: rtl/wb_arbiter_mux.sv
// Two-input write-back select: load data when memtoreg is set, ALU result otherwise.
module mux #(
    parameter int W = 32
) (
    input  logic [W-1:0] rd,
    input  logic [W-1:0] result,
    input  logic         memtoreg,
    output logic [W-1:0] data_write
);

    assign data_write = memtoreg ? rd : result;

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU result path
// and the load-return path. Memory has priority; after STARVE_MAX consecutive
// contended memory wins the ALU gets one grant. Outputs are registered.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int W          = WB_W,
    parameter int AW         = WB_AW,
    parameter int STARVE_MAX = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [W-1:0]  alu_result,
    input  logic [AW-1:0] alu_waddr,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [W-1:0]  mem_rd,
    input  logic [AW-1:0] mem_waddr,
    input  logic          wb_stall,
    output logic          reg_write,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  data_write,
    output logic          memtoreg
);

    localparam int            CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;
    logic          alu_grant;
    logic          mem_grant;
    logic          transfer;
    wb_src_e       grant_src;
    logic          mux_sel;
    logic [AW-1:0] grant_addr;
    logic [W-1:0]  mux_data;

    // Grant decision; nothing is granted while in reset or stalled.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (rst_n && !wb_stall) begin
            if (alu_valid && mem_valid) begin
                if (starve_cnt_reg == CNT_MAX) begin
                    alu_grant = 1'b1;
                end else begin
                    mem_grant = 1'b1;
                end
            end else if (mem_valid) begin
                mem_grant = 1'b1;
            end else if (alu_valid) begin
                alu_grant = 1'b1;
            end
        end
    end

    assign alu_ready  = alu_grant;
    assign mem_ready  = mem_grant;
    assign transfer   = alu_grant | mem_grant;
    assign grant_src  = mem_grant ? WB_SRC_MEM : WB_SRC_ALU;
    assign mux_sel    = (grant_src == WB_SRC_MEM);
    assign grant_addr = mem_grant ? mem_waddr : alu_waddr;

    // Starvation counter: frozen under stall, cleared when the ALU is idle or
    // served, and counts memory wins taken while the ALU was waiting.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!wb_stall) begin
            if (!alu_valid || alu_grant) begin
                starve_cnt_next = '0;
            end else if (mem_grant && (starve_cnt_reg != CNT_MAX)) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end
    end

    mux #(.W(W)) u_wb_mux (
        .rd         (mem_rd),
        .result     (alu_result),
        .memtoreg   (mux_sel),
        .data_write (mux_data)
    );

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Write-back output register; writes to x0 are accepted but not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            wr_addr    <= '0;
            data_write <= '0;
            memtoreg   <= 1'b0;
        end else if (transfer) begin
            reg_write  <= (grant_addr != '0);
            wr_addr    <= grant_addr;
            data_write <= mux_data;
            memtoreg   <= mux_sel;
        end else begin
            reg_write  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: the driver predicts readys and the next
// output state from a behavioural model and queues it; a monitor compares the
// registered outputs after every edge.
module tb_wb_arbiter;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int SM = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [W-1:0]  alu_result = '0;
    logic [AW-1:0] alu_waddr = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [W-1:0]  mem_rd = '0;
    logic [AW-1:0] mem_waddr = '0;
    logic          wb_stall = 1'b0;
    logic          reg_write;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  data_write;
    logic          memtoreg;

    always #5 clk = ~clk;

    wb_arbiter #(.W(W), .AW(AW), .STARVE_MAX(SM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_result (alu_result),
        .alu_waddr  (alu_waddr),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_waddr  (mem_waddr),
        .wb_stall   (wb_stall),
        .reg_write  (reg_write),
        .wr_addr    (wr_addr),
        .data_write (data_write),
        .memtoreg   (memtoreg)
    );

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          m2r;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_out;
    int   m_wins;   // memory wins in a row while the ALU was kept waiting
    int   errors = 0;
    int   checks = 0;
    logic ga, gm;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wins     = 0;
        m_out.rw   = 1'b0;
        m_out.addr = '0;
        m_out.data = '0;
        m_out.m2r  = 1'b0;
    endtask

    // One bus cycle: drive, check readys against the model, queue next outputs.
    task automatic cycle(input logic av, input logic [W-1:0] ad, input logic [AW-1:0] aa,
                         input logic mv, input logic [W-1:0] md, input logic [AW-1:0] ma,
                         input logic st, output logic acc_a, output logic acc_m);
        logic ea, em;
        @(negedge clk);
        alu_valid = av; alu_result = ad; alu_waddr = aa;
        mem_valid = mv; mem_rd = md; mem_waddr = ma;
        wb_stall = st;
        #1;
        ea = 1'b0;
        em = 1'b0;
        if (!st) begin
            if (av && mv) begin
                if (m_wins >= SM) ea = 1'b1;
                else em = 1'b1;
            end else begin
                ea = av;
                em = mv;
            end
        end
        chk("alu_ready", alu_ready, ea);
        chk("mem_ready", mem_ready, em);
        if (!st) begin
            if (!av || ea) m_wins = 0;
            else if (em && m_wins < SM) m_wins++;
        end
        m_out.rw = 1'b0;
        if (ea) begin
            m_out.rw = (aa != 0); m_out.addr = aa; m_out.data = ad; m_out.m2r = 1'b0;
        end
        if (em) begin
            m_out.rw = (ma != 0); m_out.addr = ma; m_out.data = md; m_out.m2r = 1'b1;
        end
        exp_q.push_back(m_out);
        $display("cyc av=%0b mv=%0b st=%0b -> grant alu=%0b mem=%0b", av, mv, st, ea, em);
        acc_a = ea;
        acc_m = em;
    endtask

    // Monitor: compare registered outputs just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("reg_write", reg_write, e.rw);
                chk("wr_addr", wr_addr, e.addr);
                chk("data_write", data_write, e.data);
                chk("memtoreg", memtoreg, e.m2r);
            end
        end
    end

    initial begin
        logic          av, mv, st;
        logic [W-1:0]  ad, md;
        logic [AW-1:0] aa, ma;
        logic          pa, pm;

        // Reset with both sources requesting.
        model_reset();
        alu_valid = 1'b1; mem_valid = 1'b1;
        #12;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_data_write", data_write, 0);
        chk("rst_memtoreg", memtoreg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 32'h1234_0001, 5'd1, 1, 32'h5678_0002, 5'd2, 0, ga, gm);
        chk("first_grant_mem", gm, 1);

        // Single ALU transfer, then idle.
        cycle(1, 32'h1111_2222, 5'd3, 0, 32'h0, 5'd0, 0, ga, gm);
        cycle(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, ga, gm);

        // Contention for six cycles: M, M, A, M, M, A.
        for (int i = 0; i < 6; i++)
            cycle(1, 32'h0000_FFFF, 5'd6, 1, 32'hAAAA_BBBB, 5'd5, 0, ga, gm);

        // Load to x0: accepted, write suppressed.
        cycle(0, 32'h0, 5'd0, 1, 32'hFFFF_FFFF, 5'd0, 0, ga, gm);

        // Stall with one memory win banked, then M then A.
        cycle(1, 32'h0000_0A0A, 5'd9, 1, 32'h0000_0B0B, 5'd10, 0, ga, gm);
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h0000_0A0A, 5'd9, 1, 32'h0000_0C0C, 5'd11, 1, ga, gm);
        cycle(1, 32'h0000_0A0A, 5'd9, 1, 32'h0000_0C0C, 5'd11, 0, ga, gm);
        chk("post_stall_mem", gm, 1);
        cycle(1, 32'h0000_0A0A, 5'd9, 1, 32'h0000_0D0D, 5'd12, 0, ga, gm);
        chk("post_stall_alu", ga, 1);

        // Asynchronous reset between edges while a transfer is pending.
        cycle(1, 32'h1234_5678, 5'd7, 0, 32'h0, 5'd0, 0, ga, gm);
        @(negedge clk);
        alu_valid = 1'b1; alu_result = 32'hDEAD_BEEF; alu_waddr = 5'd8;
        mem_valid = 1'b0; wb_stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_reg_write", reg_write, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_data_write", data_write, 0);
        chk("midrst_memtoreg", memtoreg, 0);
        chk("midrst_alu_ready", alu_ready, 0);
        model_reset();
        @(negedge clk);
        alu_valid = 1'b0;
        rst_n = 1'b1;
        cycle(0, 32'h0, 5'd0, 0, 32'h0, 5'd0, 0, ga, gm);

        // Randomised traffic; each source holds its request until accepted.
        av = 1'b0; mv = 1'b0; pa = 1'b0; pm = 1'b0;
        ad = '0; md = '0; aa = '0; ma = '0;
        for (int i = 0; i < 400; i++) begin
            if (!av || pa) begin
                av = ($urandom_range(0, 99) < 60);
                ad = $urandom;
                aa = AW'($urandom_range(0, 31));
            end
            if (!mv || pm) begin
                mv = ($urandom_range(0, 99) < 60);
                md = $urandom;
                ma = AW'($urandom_range(0, 31));
            end
            st = ($urandom_range(0, 9) < 2);
            cycle(av, ad, aa, mv, md, ma, st, pa, pm);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sharing the single register-file write port between the ALU result path and the memory load-return path. Accepts valid/ready transfers from both sources, resolves contention with memory priority plus a starvation guard, and drives registered write-back outputs (`reg_write`, `wr_addr`, `data_write`, `memtoreg`) into the register file. It sits between the execute/memory stages and the register file and feeds the existing write-back select `mux`.

## Interface
- `W`, 32, data width
- `AW`, 5, register address width
- `STARVE_MAX`, 2, consecutive contended memory grants after which the ALU is granted (≥1)

- `clk` in 1 system clock, rising edge
- `rst_n` in 1 asynchronous active-low reset
- `alu_valid` in 1 ALU result available
- `alu_ready` out 1 ALU transfer accepted this cycle (combinational)
- `alu_result` in W ALU result data
- `alu_waddr` in AW ALU destination register
- `mem_valid` in 1 load data available
- `mem_ready` out 1 load transfer accepted this cycle (combinational)
- `mem_rd` in W load data from memory
- `mem_waddr` in AW load destination register
- `wb_stall` in 1 register file cannot accept a write; blocks all grants
- `reg_write` out 1 register-file write enable (registered)
- `wr_addr` out AW write address (registered)
- `data_write` out W write data (registered)
- `memtoreg` out 1 source of the last write: 1 = memory, 0 = ALU (registered)

## Operation
- A transfer occurs on a source when `valid && ready` at a rising edge. The source holds data and address stable while `valid && !ready`.
- Grant rules (combinational, from inputs and `starve_cnt`):
  - `wb_stall`=1 → both readys 0.
  - Only one valid → that source is granted.
  - Both valid → memory is granted unless `starve_cnt == STARVE_MAX`, in which case the ALU is granted.
  - At most one ready is high in any cycle.
- `starve_cnt` (width clog2(STARVE_MAX+1)):
  - Increments on a memory grant while `alu_valid`=1.
  - Clears on an ALU grant, or on any cycle with `alu_valid`=0.
  - Holds while `wb_stall`=1.
  - Saturates at `STARVE_MAX`.
- Output register, updated on each transfer:
  - `wr_addr`, `data_write` ← the granted source's address/data.
  - `memtoreg` ← 1 for memory, 0 for ALU.
  - `reg_write` ← 1 unless the address is 0, in which case `reg_write` ← 0 (x0 write suppressed; the transfer is still accepted).
- With no transfer: `reg_write` ← 0; `wr_addr`, `data_write`, `memtoreg` hold.
- `data_write` is selected through the write-back mux using the grant as `memtoreg`, then registered.

## Timing
- Reset (asynchronous, `rst_n`=0): `reg_write`=0, `wr_addr`=0, `data_write`=0, `memtoreg`=0, `starve_cnt`=0.
- While in reset, `alu_ready`=`mem_ready`=0 regardless of valids.
- Latency: a transfer at edge N appears on the outputs after edge N (visible in cycle N+1). `reg_write` is a single-cycle pulse per transfer.
- Throughput: one write per cycle. Back-to-back transfers from the same or alternating sources are allowed.
- Contention with `STARVE_MAX`=2 and both valid continuously: grant order MEM, MEM, ALU, MEM, MEM, ALU, …
- `wb_stall` rising mid-stream: no transfer that cycle, `reg_write`=0 the next cycle, counter frozen. Arbitration resumes from the frozen count when the stall falls.
- Reset asserted mid-operation discards any pending grant. The source must re-present its data after reset.

## Structure
- Package `wb_pkg`: enum `wb_src_e` {`WB_SRC_ALU`=0, `WB_SRC_MEM`=1} (value equals `memtoreg`), localparam defaults for `W` and `AW`.
- Sub-module: instantiate the existing two-input write-back `mux` (`rd`, `result`, `memtoreg`, `data_write`) for the data select ahead of the output register. All other logic stays in `wb_arbiter`.

## Test plan
- Reset: drive `rst_n`=0 with both valids high → all outputs 0, both readys 0. Release → the first grant goes to memory.
- Single source: ALU `alu_result`=32'h1111_2222, `alu_waddr`=3 for one cycle → `alu_ready`=1; next cycle `reg_write`=1, `wr_addr`=3, `data_write`=32'h1111_2222, `memtoreg`=0.
- Contention: both valid for 6 cycles, `mem_rd`=32'hAAAA_BBBB (addr 5), ALU 32'h0000_FFFF (addr 6) → grant order M, M, A, M, M, A. Outputs mirror this one cycle later, with `memtoreg` 1, 1, 0, 1, 1, 0.
- x0 suppression: memory load to `mem_waddr`=0 with 32'hFFFF_FFFF → `mem_ready`=1; next cycle `reg_write`=0, `data_write`=32'hFFFF_FFFF, `memtoreg`=1.
- Stall: both valid with `starve_cnt`=1, `wb_stall`=1 for 3 cycles → readys 0 and `reg_write`=0 throughout, counter stays 1. After release: one M, then A.
- Mid-operation reset: assert `rst_n`=0 asynchronously between edges during a transfer → outputs go to 0 immediately, with no write pulse after release.
